// File: rtl/bones_pkg.sv
// Shared types and uio bit positions for the bones frequency meter.
package bones_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    GATE,
    DONE
  } state_e;

  localparam int SEL_LSB   = 0;
  localparam int BSEL_LSB  = 3;
  localparam int START_BIT = 5;
  localparam int CONT_BIT  = 6;
  localparam int DONE_BIT  = 7;

  localparam logic [7:0] UIO_OE_VAL = 8'h80;

endpackage

// File: rtl/bones_edge_sync.sv
// Two-flop synchroniser for an asynchronous level, plus a one-cycle rising-edge pulse.
module bones_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: non-blocking assignments keep the three stages a true shift chain; blocking would collapse them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/tt_um_bones_freq_meter.sv
// Gated edge counter for ring-oscillator taps; the saturating result is read out byte by byte.
module tt_um_bones_freq_meter
  import bones_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int GATE_LOG2 = 10,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int             GW        = GATE_LOG2 + 1;
  localparam logic [GW-1:0]  GATE_LAST = GW'((1 << GATE_LOG2) - 1);

  logic [7:0]       tap_pulse;
  logic             start_pulse;
  state_e           state_q, state_d;
  logic [2:0]       sel_q;
  logic             cont_q;
  logic [GW-1:0]    gate_cnt_q;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] result_q;
  logic             done_q;
  logic [31:0]      result_ext;
  logic             unused;

  // Channels beyond CHANNELS have no synchroniser and never pulse, so selecting them counts nothing.
  for (genvar i = 0; i < 8; i++) begin : g_tap
    if (i < CHANNELS) begin : g_on
      bones_edge_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ui_in[i]),
        .pulse    (tap_pulse[i])
      );
    end else begin : g_off
      assign tap_pulse[i] = 1'b0;
    end
  end

  bones_edge_sync u_start_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (uio_in[START_BIT]),
    .pulse    (start_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_pulse) state_d = ARM;
      ARM:     state_d = GATE;
      GATE:    if (gate_cnt_q == GATE_LAST) state_d = DONE;
      DONE:    if (cont_q || start_pulse) state_d = ARM;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (tap_pulse[sel_q] && (edge_cnt_q != '1)) edge_cnt_d = edge_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= '0;
      cont_q     <= 1'b0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      // done drops on entry to ARM so it reads low for the whole ARM cycle, except on a continuous re-arm.
      if ((state_d == ARM) && (state_q != ARM) && !((state_q == DONE) && cont_q))
        done_q <= 1'b0;
      if (state_q == ARM) begin
        sel_q      <= uio_in[SEL_LSB +: 3];
        gate_cnt_q <= '0;
        edge_cnt_q <= '0;
      end
      if (state_q == GATE) begin
        gate_cnt_q <= gate_cnt_q + GW'(1);
        edge_cnt_q <= edge_cnt_d;
      end
      // Capture includes a pulse arriving in the final gate cycle.
      if ((state_q == GATE) && (state_d == DONE)) begin
        result_q <= edge_cnt_d;
        done_q   <= 1'b1;
        cont_q   <= uio_in[CONT_BIT];
      end
    end
  end

  assign result_ext = 32'(result_q);
  assign uo_out     = result_ext[{uio_in[BSEL_LSB +: 2], 3'b000} +: 8];
  assign uio_out    = 8'(done_q) << DONE_BIT;
  assign uio_oe     = UIO_OE_VAL;

  assign unused = &{1'b0, ena, ui_in, uio_in[7]};

endmodule

// File: tb/tb_tt_um_bones_freq_meter.sv
// Directed bench for the bones frequency meter: three configurations share stimulus, results go through a scoreboard.
module tb_tt_um_bones_freq_meter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_a, uio_out_a, uio_oe_a;
  logic [7:0] uo_b, uio_out_b, uio_oe_b;
  logic [7:0] uo_c, uio_out_c, uio_oe_c;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   half[8]  = '{default: 0};

  always #5 clk = ~clk;

  tt_um_bones_freq_meter #(.CHANNELS(4), .GATE_LOG2(4), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_a), .uio_out(uio_out_a), .uio_oe(uio_oe_a)
  );

  tt_um_bones_freq_meter #(.CHANNELS(4), .GATE_LOG2(10), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_b), .uio_out(uio_out_b), .uio_oe(uio_oe_b)
  );

  tt_um_bones_freq_meter #(.CHANNELS(4), .GATE_LOG2(10), .CNT_W(16)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_c), .uio_out(uio_out_c), .uio_oe(uio_oe_c)
  );

  // Square-wave taps: channel c toggles every half[c] cycles (0 = static), updated away from the active edge.
  initial begin
    int phase[8];
    ui_in = 8'h00;
    for (int c = 0; c < 8; c++) phase[c] = 0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 8; c++) begin
        if (half[c] != 0) begin
          phase[c]++;
          if (phase[c] >= half[c]) begin
            phase[c] = 0;
            ui_in[c] = ~ui_in[c];
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL sb_underflow observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic read_byte(input int inst, input logic [1:0] b, output logic [7:0] v);
    uio_in[4:3] = b;
    #1;
    case (inst)
      0:       v = uo_a;
      1:       v = uo_b;
      default: v = uo_c;
    endcase
    uio_in[4:3] = 2'd0;
  endtask

  // Counts clock edges after start is raised until instance A shows done high after having shown it low.
  task automatic wait_done_a(output int n, output int n_low);
    n     = 0;
    n_low = -1;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (!uio_out_a[7] && (n_low < 0)) n_low = n;
      if (uio_out_a[7] && (n_low >= 0)) break;
    end
  endtask

  task automatic run_a(input logic [2:0] sel, input logic [2:0] mid_sel, input bit toggle_mid,
                       input string tag, input logic [15:0] exp, input bit from_done);
    int         n, n_low;
    logic [7:0] v0, v1;
    uio_in[2:0] = sel;
    uio_in[6]   = 1'b0;
    uio_in[5]   = 1'b0;
    repeat (3) @(negedge clk);
    sb.push_back('{tag: tag, exp: 32'(exp)});
    uio_in[5] = 1'b1;
    n     = 0;
    n_low = -1;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 6) uio_in[2:0] = mid_sel;
      if (toggle_mid && (n == 8))  uio_in[5] = 1'b0;
      if (toggle_mid && (n == 10)) uio_in[5] = 1'b1;
      if (!uio_out_a[7] && (n_low < 0)) n_low = n;
      if (uio_out_a[7] && (n_low >= 0)) break;
    end
    check({tag, "_latency"}, n, 20);
    if (from_done) check({tag, "_done_fall"}, n_low, 3);
    read_byte(0, 2'd0, v0);
    read_byte(0, 2'd1, v1);
    sb_check({16'h0, v1, v0});
    uio_in[5] = 1'b0;
  endtask

  initial begin
    int         n, n_low, lows;
    logic [7:0] v, c0, c1, c2, c3;

    rst_n   = 1'b0;
    uio_in  = 8'h00;
    half[0] = 1;
    half[1] = 2;
    repeat (4) @(negedge clk);
    check("rst_uo_a", uo_a, 8'h00);
    check("rst_uio_out_a", uio_out_a, 8'h00);
    check("rst_uio_oe_a", uio_oe_a, 8'h80);
    check("rst_uio_oe_b", uio_oe_b, 8'h80);
    check("rst_uo_c", uo_c, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Long windows: ch0 toggles every cycle, 512 edges in 1024 cycles.
    uio_in[2:0] = 3'd0;
    sb.push_back('{tag: "a_ch0_p2", exp: 32'd8});
    sb.push_back('{tag: "b_saturate", exp: 32'hFF});
    sb.push_back('{tag: "c_512", exp: 32'd512});
    uio_in[5] = 1'b1;
    n = 0;
    while ((n < 1100) && !uio_out_c[7]) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("c_latency", n, 1028);
    check("b_done", uio_out_b[7], 1'b1);
    read_byte(0, 2'd0, c0);
    read_byte(0, 2'd1, c1);
    sb_check({16'h0, c1, c0});
    read_byte(1, 2'd0, v);
    sb_check({24'h0, v});
    read_byte(1, 2'd1, v);
    check("b_byte1_above_cnt_w", v, 8'h00);
    read_byte(2, 2'd0, c0);
    read_byte(2, 2'd1, c1);
    read_byte(2, 2'd2, c2);
    read_byte(2, 2'd3, c3);
    sb_check({c3, c2, c1, c0});
    check("c_byte1", c1, 8'h02);
    check("c_byte2", c2, 8'h00);
    check("c_byte3", c3, 8'h00);
    uio_in[5] = 1'b0;

    // Single-shot on ch1 (period 4); select change and start edge mid-gate must not disturb the window.
    run_a(3'd1, 3'd1, 1'b0, "ch1_p4", 16'd4, 1'b1);
    run_a(3'd1, 3'd0, 1'b0, "ch1_midsel", 16'd4, 1'b1);
    run_a(3'd1, 3'd1, 1'b1, "ch1_start_toggle", 16'd4, 1'b1);

    for (int c = 2; c < 8; c++) half[c] = 1;
    run_a(3'd6, 3'd6, 1'b0, "sel6_none", 16'd0, 1'b1);

    // Continuous mode on ch3: period 8 then period 4.
    half[3] = 4;
    repeat (20) @(negedge clk);
    uio_in[2:0] = 3'd3;
    uio_in[6]   = 1'b1;
    uio_in[5]   = 1'b0;
    repeat (3) @(negedge clk);
    sb.push_back('{tag: "cont_w1", exp: 32'd2});
    sb.push_back('{tag: "cont_w2", exp: 32'd2});
    uio_in[5] = 1'b1;
    wait_done_a(n, n_low);
    check("cont_latency", n, 20);
    read_byte(0, 2'd0, v);
    sb_check({24'h0, v});
    lows = 0;
    repeat (18) begin @(posedge clk); #1; if (!uio_out_a[7]) lows++; end
    read_byte(0, 2'd0, v);
    sb_check({24'h0, v});
    half[3] = 2;
    repeat (18) begin @(posedge clk); #1; if (!uio_out_a[7]) lows++; end
    sb.push_back('{tag: "cont_w4", exp: 32'd4});
    repeat (18) begin @(posedge clk); #1; if (!uio_out_a[7]) lows++; end
    read_byte(0, 2'd0, v);
    sb_check({24'h0, v});
    repeat (5) begin @(posedge clk); #1; if (!uio_out_a[7]) lows++; end
    uio_in[6] = 1'b0;
    repeat (13) begin @(posedge clk); #1; if (!uio_out_a[7]) lows++; end
    read_byte(0, 2'd0, v);
    check("cont_last_window", v, 8'd4);
    half[3] = 4;
    repeat (40) begin @(posedge clk); #1; if (!uio_out_a[7]) lows++; end
    read_byte(0, 2'd0, v);
    check("cont_stopped_result", v, 8'd4);
    check("cont_done_never_low", lows, 0);
    uio_in[5] = 1'b0;

    // Reset in the middle of a continuous gate window while done is high.
    uio_in[6] = 1'b1;
    repeat (3) @(negedge clk);
    uio_in[5] = 1'b1;
    wait_done_a(n, n_low);
    check("rst_run_latency", n, 20);
    repeat (8) @(posedge clk);
    #1;
    check("pre_rst_done", uio_out_a[7], 1'b1);
    read_byte(0, 2'd0, v);
    check("pre_rst_uo", v, 8'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_uo", uo_a, 8'h00);
    check("mid_rst_uio_out", uio_out_a, 8'h00);
    check("mid_rst_uio_oe", uio_oe_a, 8'h80);
    uio_in[6] = 1'b0;
    uio_in[5] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_idle_done", uio_out_a[7], 1'b0);
    check("post_rst_idle_uo", uo_a, 8'h00);

    run_a(3'd1, 3'd1, 1'b0, "after_rst", 16'd4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
